// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit that sequences data_path.
// Opcode, FSM state and instruction-class encodings plus instruction field positions.
package ctrl_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LDR  = 4'h7,
        OP_STR  = 4'h8,
        OP_JMP  = 4'h9,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EXEC    = 4'd3,
        ST_WAIT_DP = 4'd4,
        ST_MEM     = 4'd5,
        ST_WB      = 4'd6,
        ST_NEXT    = 4'd7,
        ST_HALT    = 4'd8
    } state_t;

    // ADDI decodes to CLS_ALU; it differs only by alu_in_sel.
    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_ALU = 3'd1,
        CLS_LDR = 3'd2,
        CLS_STR = 3'd3,
        CLS_JMP = 3'd4,
        CLS_HLT = 3'd5,
        CLS_ILL = 3'd6
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

endpackage

// File: rtl/ctrl_unit_if.sv
// Instruction- and data-memory buses between ctrl_unit (master) and the memories (slave).
// Handshake: req is held high until the cycle in which ack is high; that cycle completes the
// access (ack may arrive in the first req cycle), and ack while req is low is ignored.
interface ctrl_unit_if #(parameter int DWIDTH = 16);
    logic              imem_req;
    logic [7:0]        imem_addr;
    logic              imem_ack;
    logic [DWIDTH-1:0] imem_data;
    logic              dmem_req;
    logic              dmem_we;
    logic [7:0]        dmem_addr;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        input  imem_ack, imem_data, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        output imem_ack, imem_data, dmem_ack
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the data_path ALU controls.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output cls_t       o_cls,
    output logic [2:0] o_alu_func,
    output logic       o_alu_in_sel,
    output logic       o_ldr_sel,
    output logic       o_illegal
);

    always_comb begin
        o_cls        = CLS_NOP;
        o_alu_func   = ALU_ADD;
        o_alu_in_sel = 1'b0;
        o_ldr_sel    = 1'b0;
        o_illegal    = 1'b0;
        case (i_op)
            OP_NOP:  o_cls = CLS_NOP;
            OP_ADD:  o_cls = CLS_ALU;
            OP_SUB:  begin o_cls = CLS_ALU; o_alu_func = ALU_SUB; end
            OP_AND:  begin o_cls = CLS_ALU; o_alu_func = ALU_AND; end
            OP_OR:   begin o_cls = CLS_ALU; o_alu_func = ALU_OR;  end
            OP_XOR:  begin o_cls = CLS_ALU; o_alu_func = ALU_XOR; end
            OP_ADDI: begin o_cls = CLS_ALU; o_alu_in_sel = 1'b1; end
            OP_LDR:  begin o_cls = CLS_LDR; o_ldr_sel = 1'b1; end
            OP_STR:  o_cls = CLS_STR;
            OP_JMP:  o_cls = CLS_JMP;
            OP_HLT:  o_cls = CLS_HLT;
            default: begin o_cls = CLS_ILL; o_illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: fetches and decodes 16-bit instructions, sequences data_path
// through EXEC/WAIT_DP/WB and runs the data-memory handshake for LDR/STR.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] pc_in,
    ctrl_unit_if.master       bus,
    input  logic              dp_done,
    output logic              en_in,
    output logic              en_pc_pulse,
    output logic              alu_in_sel,
    output logic              ldr_sel,
    output logic [1:0]        pc_ctrl,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [3:0]        reg_en,
    output logic [2:0]        alu_func,
    output logic [7:0]        offset,
    output logic [7:0]        offset_addr,
    output logic              halted,
    output logic              error,
    output state_t            dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state, w_next;
    logic [DWIDTH-1:0] r_ir;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_error, w_set_err;
    cls_t              w_cls;
    logic              w_illegal;
    logic              w_unused_pc;

    ctrl_decode u_decode (
        .i_op        (r_ir[OP_MSB:OP_LSB]),
        .o_cls       (w_cls),
        .o_alu_func  (alu_func),
        .o_alu_in_sel(alu_in_sel),
        .o_ldr_sel   (ldr_sel),
        .o_illegal   (w_illegal)
    );

    // Decoded fields come straight off IR, so they are valid throughout DECODE and stay
    // put until the next fetch overwrites IR at the start of the following DECODE.
    assign rd            = r_ir[RD_MSB:RD_LSB];
    assign rs            = r_ir[RS_MSB:RS_LSB];
    assign offset        = r_ir[IMM_MSB:IMM_LSB];
    assign offset_addr   = r_ir[IMM_MSB:IMM_LSB];
    assign bus.dmem_addr = r_ir[IMM_MSB:IMM_LSB];
    assign bus.imem_addr = pc_in[7:0];
    assign w_unused_pc   = ^pc_in[DWIDTH-1:8];
    assign error         = r_error;
    assign dbg_state     = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        w_set_err       = 1'b0;
        bus.imem_req    = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.dmem_we     = 1'b0;
        en_in           = 1'b0;
        en_pc_pulse     = 1'b0;
        pc_ctrl         = PC_HOLD;
        reg_en          = 4'b0000;
        halted          = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_FETCH;
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    w_next    = ST_HALT;
                    w_set_err = 1'b1;
                end else begin
                    case (w_cls)
                        CLS_ALU, CLS_STR: w_next = ST_EXEC;
                        CLS_LDR:          w_next = ST_MEM;
                        CLS_HLT:          w_next = ST_HALT;
                        default:          w_next = ST_NEXT;
                    endcase
                end
            end
            ST_EXEC: begin
                en_in  = 1'b1;
                w_next = ST_WAIT_DP;
            end
            ST_WAIT_DP: begin
                if (dp_done) begin
                    w_next = (w_cls == CLS_STR) ? ST_MEM : ST_WB;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next    = ST_HALT;
                    w_set_err = 1'b1;
                end
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (w_cls == CLS_STR);
                if (bus.dmem_ack) w_next = (w_cls == CLS_LDR) ? ST_WB : ST_NEXT;
            end
            ST_WB: begin
                en_in  = 1'b1;
                reg_en = 4'b0001 << rd;
                w_next = ST_NEXT;
            end
            ST_NEXT: begin
                en_pc_pulse = 1'b1;
                pc_ctrl     = (w_cls == CLS_JMP) ? PC_LOAD : PC_INC;
                w_next      = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir    <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == ST_FETCH && bus.imem_ack) r_ir <= bus.imem_data;
            if (r_state == ST_EXEC)         r_cnt <= '0;
            else if (r_state == ST_WAIT_DP) r_cnt <= r_cnt + 1'b1;
            if (w_set_err) r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: zero-wait instruction memory, a data_path model that pulses
// dp_done a fixed latency after EXEC, and a data-memory model with programmable wait states.
module tb_ctrl_unit;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, dp_done;
    logic [15:0] pc_in;
    logic        en_in, en_pc_pulse, alu_in_sel, ldr_sel, halted, error;
    logic [1:0]  pc_ctrl, rd, rs;
    logic [3:0]  reg_en;
    logic [2:0]  alu_func;
    logic [7:0]  offset, offset_addr;
    state_t      dbg_state;

    int dp_lat, dmem_wait, cyc, n_wait;
    bit dp_hold;
    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_next_q[$];   // {pc_ctrl, offset_addr} at each en_pc_pulse
    logic [4:0] exp_wb_q[$];     // {ldr_sel, reg_en} at each write-back

    ctrl_unit_if #(.DWIDTH(16)) bus ();

    ctrl_unit #(.DWIDTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .bus(bus), .dp_done(dp_done),
        .en_in(en_in), .en_pc_pulse(en_pc_pulse), .alu_in_sel(alu_in_sel), .ldr_sel(ldr_sel),
        .pc_ctrl(pc_ctrl), .rd(rd), .rs(rs), .reg_en(reg_en), .alu_func(alu_func),
        .offset(offset), .offset_addr(offset_addr), .halted(halted), .error(error),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign bus.imem_ack = bus.imem_req;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, "_strobes"}, {23'b0, bus.imem_req, bus.dmem_req, bus.dmem_we, en_in,
              en_pc_pulse, alu_in_sel, ldr_sel, halted, error}, 32'd0);
        check({tag, "_fields"}, {18'b0, pc_ctrl, rd, rs, reg_en, alu_func}, 32'd0);
        check({tag, "_bytes"}, {8'b0, offset, offset_addr, bus.dmem_addr}, 32'd0);
    endtask

    // Steps from instruction cycle k0 to the NEXT cycle; returns its 1-based index.
    task automatic run_to_next(input int k0, output int k);
        k = k0;
        for (int i = 0; i < 60 && !en_pc_pulse; i++) begin
            step();
            k++;
        end
        if (!en_pc_pulse) k = -1;
    endtask

    // data_path model: dp_done pulses dp_lat cycles after the EXEC en_in cycle.
    initial begin
        forever begin
            step();
            if (en_in && reg_en == 4'b0000 && !dp_hold) begin
                repeat (dp_lat) step();
                dp_done = 1'b1;
                step();
                dp_done = 1'b0;
            end
        end
    end

    // Data memory model: ack after dmem_wait wait cycles if the request is still up.
    initial begin
        forever begin
            step();
            if (bus.dmem_req) begin
                repeat (dmem_wait) step();
                if (bus.dmem_req) begin
                    bus.dmem_ack = 1'b1;
                    step();
                    bus.dmem_ack = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every PC update and register write must match the next queued expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (en_in || en_pc_pulse)
                check("en_exclusive", {31'b0, en_in & en_pc_pulse}, 32'd0);
            if (en_pc_pulse) begin
                e = (exp_next_q.size() != 0) ? {22'b0, exp_next_q.pop_front()} : '1;
                check("next_pc", {22'b0, pc_ctrl, offset_addr}, e);
            end
            if (reg_en != 4'b0000) begin
                e = (exp_wb_q.size() != 0) ? {27'b0, exp_wb_q.pop_front()} : '1;
                check("wb_regen", {27'b0, ldr_sel, reg_en}, e);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; pc_in = 16'h0000; dp_done = 1'b0;
        bus.dmem_ack = 1'b0; bus.imem_data = 16'h0000;
        dp_lat = 3; dmem_wait = 0; dp_hold = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        check("reset_imem_addr", {24'b0, bus.imem_addr}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_no_start", 32'(dbg_state), 32'(ST_IDLE));
        pc_in = 16'h0010;
        start = 1'b1;
        step();
        start = 1'b0;

        // ADD r1,r2
        check("add_fetch", {23'b0, bus.imem_req, bus.imem_addr}, {23'b0, 1'b1, 8'h10});
        bus.imem_data = 16'h1600;
        exp_wb_q.push_back({1'b0, 4'b0010});
        exp_next_q.push_back({PC_INC, 8'h00});
        step();
        check("add_decode", {24'b0, rd, rs, alu_func, alu_in_sel}, {24'b0, 2'd1, 2'd2, ALU_ADD, 1'b0});
        run_to_next(2, cyc);
        check("add_cycles", cyc, 8);

        // SUB, AND, OR, XOR with rotating register fields
        for (int op = 2; op <= 5; op++) begin
            step();
            check("alu_fetch", {31'b0, bus.imem_req}, 32'd1);
            bus.imem_data = {4'(op), 2'(op % 4), 2'(3 - op % 4), 8'(op * 7)};
            exp_wb_q.push_back({1'b0, 4'(1 << (op % 4))});
            exp_next_q.push_back({PC_INC, 8'(op * 7)});
            step();
            check("alu_decode", {22'b0, rd, rs, alu_func, alu_in_sel, ldr_sel},
                  {22'b0, 2'(op % 4), 2'(3 - op % 4), 3'(op - 1), 1'b0, 1'b0});
            run_to_next(2, cyc);
            check("alu_cycles", cyc, 8);
        end

        // ADDI r0,r2,5
        step();
        bus.imem_data = 16'h6205;
        exp_wb_q.push_back({1'b0, 4'b0001});
        exp_next_q.push_back({PC_INC, 8'h05});
        step();
        check("addi_decode", {17'b0, offset, alu_in_sel, alu_func, rd, rs},
              {17'b0, 8'h05, 1'b1, ALU_ADD, 2'd0, 2'd2});
        run_to_next(2, cyc);
        check("addi_cycles", cyc, 8);

        // LDR r3,0x3A with two memory wait cycles
        step();
        check("addi_fields_held", {23'b0, offset, alu_in_sel}, {23'b0, 8'h05, 1'b1});
        pc_in = 16'h1234;
        #1;
        check("imem_addr_low_byte", {24'b0, bus.imem_addr}, 32'h34);
        bus.imem_data = 16'h7C3A;
        dmem_wait = 2;
        exp_wb_q.push_back({1'b1, 4'b1000});
        exp_next_q.push_back({PC_INC, 8'h3A});
        step();
        check("ldr_decode", {21'b0, ldr_sel, rd, offset}, {21'b0, 1'b1, 2'd3, 8'h3A});
        step();
        check("ldr_mem", {22'b0, bus.dmem_req, bus.dmem_we, bus.dmem_addr}, {22'b0, 1'b1, 1'b0, 8'h3A});
        run_to_next(3, cyc);
        check("ldr_cycles", cyc, 7);

        // STR rs=1 to 0x40, zero-wait memory
        step();
        bus.imem_data = 16'h8140;
        dmem_wait = 0;
        exp_next_q.push_back({PC_INC, 8'h40});
        step();
        check("str_decode_rs", {30'b0, rs}, 32'd1);
        step();
        check("str_exec", {27'b0, en_in, reg_en}, {27'b0, 1'b1, 4'b0000});
        cyc = 3;
        for (int i = 0; i < 30 && !bus.dmem_req; i++) begin
            step();
            cyc++;
        end
        check("str_mem_cycle", cyc, 7);
        check("str_mem", {22'b0, bus.dmem_req, bus.dmem_we, bus.dmem_addr}, {22'b0, 1'b1, 1'b1, 8'h40});
        run_to_next(cyc, cyc);
        check("str_cycles", cyc, 8);

        // NOP, then JMP 0x12
        step();
        bus.imem_data = 16'h0000;
        exp_next_q.push_back({PC_INC, 8'h00});
        run_to_next(1, cyc);
        check("nop_cycles", cyc, 3);
        step();
        bus.imem_data = 16'h9012;
        exp_next_q.push_back({PC_LOAD, 8'h12});
        run_to_next(1, cyc);
        check("jmp_cycles", cyc, 3);

        // Illegal opcode 0xA halts with error; start is then ignored
        step();
        check("ill_fetch", {31'b0, bus.imem_req}, 32'd1);
        bus.imem_data = 16'hA000;
        step();
        step();
        check("ill_halt", {30'b0, halted, error}, 32'd3);
        check("ill_state", 32'(dbg_state), 32'(ST_HALT));
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        check("halt_sticky", {27'b0, dbg_state, halted}, {27'b0, ST_HALT, 1'b1});

        // Asynchronous reset clears everything without a clock edge
        pc_in = 16'h0000;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        step();
        rst = 1'b0;
        step();

        // Withheld dp_done: 15 WAIT_DP cycles then error halt
        start = 1'b1;
        dp_hold = 1'b1;
        step();
        start = 1'b0;
        bus.imem_data = 16'h1600;
        step();
        step();
        check("to_exec", {31'b0, en_in}, 32'd1);
        n_wait = 0;
        step();
        while (dbg_state == ST_WAIT_DP && n_wait < 40) begin
            n_wait++;
            step();
        end
        check("timeout_wait_cycles", n_wait, 15);
        check("timeout_halt", {30'b0, halted, error}, 32'd3);

        // Reset in the middle of a data-memory access drops dmem_req at once
        rst = 1'b1;
        step();
        rst = 1'b0;
        dp_hold = 1'b0;
        check("error_cleared", {31'b0, error}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        bus.imem_data = 16'h7C3A;
        dmem_wait = 10;
        step();
        step();
        check("mid_mem_req", {31'b0, bus.dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_mem_drop", {30'b0, bus.imem_req, bus.dmem_req}, 32'd0);
        check("mid_mem_state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        rst = 1'b0;
        step();
        step();
        check("post_reset_idle", {27'b0, dbg_state, bus.dmem_req}, {27'b0, ST_IDLE, 1'b0});

        check("next_q_drained", exp_next_q.size(), 32'd0);
        check("wb_q_drained", exp_wb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Multi-cycle control unit that sequences `data_path`. It fetches 16-bit instructions from instruction memory at the current PC and decodes them. It drives every `data_path` control input, waits for the datapath's `en_out` completion pulse, and handles data-memory handshakes for LDR/STR. It sits beside `data_path` in the CPU top level, with the PC value and the `en_out` completion pulse fed back from `data_path`.

## Interface
- DWIDTH, 16, instruction/data word width
- TIMEOUT, 15, max cycles waiting for dp_done before error halt
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- pc_in  in  DWIDTH  `data_path` pc_out
- imem_req  out  1  instruction fetch request
- imem_addr  out  8  = pc_in[7:0]
- imem_ack  in  1  imem_data valid this cycle
- imem_data  in  DWIDTH  instruction word
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  8  = IR[7:0]
- dmem_ack  in  1  access complete (load data valid on `data_path` ldr_in)
- dp_done  in  1  `data_path` en_out
- en_in, en_pc_pulse, alu_in_sel, ldr_sel  out  1 each  to `data_path`
- pc_ctrl  out  2  00 hold, 01 increment, 10 load offset_addr, 11 reserved (never driven)
- rd, rs  out  2 each; reg_en out 4 (one-hot write enable); alu_func out 3; offset, offset_addr out 8 each
- halted  out  1  in HALT state
- error  out  1  illegal opcode or datapath timeout (sticky)

## Operation
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: alu_func 000/001/010/011/100 respectively
  - 6 ADDI: alu_func 000, alu_in_sel=1
  - 7 LDR
  - 8 STR
  - 9 JMP
  - F HLT
  - 10–14 illegal
- Every state and every transition is evaluated only on a rising edge of clk; the state encodings are in the package listed under Structure.
- States: IDLE, FETCH, DECODE, EXEC, WAIT_DP, MEM, WB, NEXT, HALT.
- IDLE -> FETCH on start=1.
- FETCH: imem_req=1 held until imem_ack; on ack, IR <= imem_data, then go to DECODE.
- DECODE (1 cycle): register rd, rs, alu_func, alu_in_sel, ldr_sel, offset=imm, offset_addr=imm. These are held constant until the next DECODE. Next state:
  - ALU, ADDI, STR -> EXEC
  - LDR -> MEM
  - NOP, JMP -> NEXT
  - HLT -> HALT
  - illegal -> HALT with error=1
- EXEC: en_in=1, reg_en=0000 for exactly one cycle, then go to WAIT_DP.
- WAIT_DP: wait for dp_done.
  - On dp_done: ALU/ADDI -> WB; STR -> MEM.
  - Counter reaches TIMEOUT without dp_done -> HALT with error=1.
- MEM: dmem_req=1 until dmem_ack; dmem_we=1 only for STR. Then LDR -> WB, STR -> NEXT.
- WB: en_in=1, reg_en=onehot(rd) for one cycle; ldr_sel=1 for LDR. Then go to NEXT.
- NEXT: en_pc_pulse=1 for one cycle; pc_ctrl=10 for JMP, otherwise 01. Then go to FETCH.
- HALT: sticky until rst; start ignored.
- pc_ctrl=00 in every state except NEXT.
- reg_en=0000 in every state except WB.

## Timing
- Reset (async): state IDLE, IR=0, timeout counter=0, all outputs 0.
- Reset mid-operation: imem_req/dmem_req drop immediately, with no completion of the in-flight access.
- Requests are level-held; ack may arrive in the first request cycle (zero wait). Ack outside FETCH/MEM is ignored.
- dp_done is sampled only in WAIT_DP; pulses in other states are ignored.
- Timeout counter clears on EXEC entry and increments each WAIT_DP cycle.
- Cycle counts with zero-wait memory and nominal datapath latency 3 (dp_done 3 cycles after en_in):
  - ALU/ADDI: 8 cycles per instruction (FETCH 1, DECODE 1, EXEC 1, WAIT_DP 3, WB 1, NEXT 1)
  - LDR: 5
  - STR: 8
  - NOP, JMP: 3
- en_in and en_pc_pulse are never high in the same cycle.

## Structure
- Package ctrl_pkg: opcode enum, state enum, ALU_* func codes, PC_HOLD/PC_INC/PC_LOAD constants, instruction field positions.
- Sub-module ctrl_decode: combinational opcode -> {class, alu_func, alu_in_sel, ldr_sel, illegal}.
- FSM, IR, timeout counter and output registers live in ctrl_unit.

## Test plan
- Reset, start=1, instr 0x1600 (ADD r1,r2), dp_done 3 cycles after en_in -> reg_en=0010 in WB; en_pc_pulse with pc_ctrl=01 exactly 8 cycles after FETCH entry.
- 0x6205 (ADDI r0,r2,5) -> offset=0x05 and alu_in_sel=1 from DECODE until the next instruction's DECODE.
- 0x7C3A (LDR r3,0x3A), dmem_ack after 2 wait cycles -> dmem_addr=0x3A, dmem_we=0, then WB with ldr_sel=1, reg_en=1000.
- 0x8140 (STR, rs=1, addr 0x40) -> en_in pulse, dmem_req after dp_done with dmem_we=1, reg_en stays 0000 throughout.
- 0x9012 (JMP 0x12) -> pc_ctrl=10, offset_addr=0x12 with en_pc_pulse; next, 0xA000 -> halted=1, error=1; rst=1 -> all outputs 0, IDLE.
- dp_done withheld after EXEC -> halted=1, error=1 after 15 WAIT_DP cycles; reset asserted mid-MEM drops dmem_req asynchronously.
